// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master drives start/op/in1/in2; slave returns busy/done/hi/lo.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in1, in2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU.
// Ports: clk, rst (sync, active-high), bus (muldiv_unit_if.slave).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ah_q, ah_d;
  logic [WIDTH-1:0] al_q, al_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_n;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // op[0]=1 selects the unsigned variants
  assign s1   = ~bus.op[0] & bus.in1[WIDTH-1];
  assign s2   = ~bus.op[0] & bus.in2[WIDTH-1];
  assign mag1 = s1 ? -bus.in1 : bus.in1;
  assign mag2 = s2 ? -bus.in2 : bus.in2;

  assign accept = bus.start &&
                  (state_q == IDLE || state_q == DONE);

  // multiply: {ah,al} is the product/multiplier shift pair
  assign mul_sum = {1'b0, ah_q} +
                   (al_q[0] ? {1'b0, b_q} : '0);

  // divide: ah is the partial remainder, al the dividend/quotient
  assign r_sh = {ah_q, al_q[WIDTH-1]};
  assign diff = r_sh - {1'b0, b_q};

  assign prod   = {ah_q, al_q};
  assign prod_n = -prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    b_d      = b_q;
    ah_d     = ah_q;
    al_d     = al_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = CALC;
          cnt_d    = CW'(WIDTH - 1);
          div_d    = bus.op[1];
          neg_lo_d = s1 ^ s2;
          neg_hi_d = s1;
          dz_d     = (bus.in2 == '0);
          b_d      = mag2;
          ah_d     = '0;
          al_d     = mag1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // counter wraps below zero once all WIDTH steps are done
        if (cnt_q[CW-1]) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (div_q) begin
            if (!diff[WIDTH]) begin
              ah_d = diff[WIDTH-1:0];
              al_d = {al_q[WIDTH-2:0], 1'b1};
            end else begin
              ah_d = r_sh[WIDTH-1:0];
              al_d = {al_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            ah_d = mul_sum[WIDTH:1];
            al_d = {mul_sum[0], al_q[WIDTH-1:1]};
          end
        end
      end
      FIX: begin
        state_d = DONE;
        if (div_q) begin
          // remainder keeps the dividend sign, so a zero
          // divisor hands back in1 unchanged
          hi_d = neg_hi_q ? -ah_q : ah_q;
          if (dz_q)
            lo_d = '1;
          else
            lo_d = neg_lo_q ? -al_q : al_q;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? prod_n : prod;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      b_q      <= '0;
      ah_q     <= '0;
      al_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      b_q      <= b_d;
      ah_q     <= ah_d;
      al_q     <= al_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit.
// Stimulus pushes expected {hi,lo}; a negedge monitor pops on done.
module tb_muldiv_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_run = 0;
  logic [63:0] last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa, sb2;
    logic [63:0] ua, ub;
    int          ia, ib;
    logic [31:0] q, r;
    case (op)
      2'b00: begin
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        return 64'(sa * sb2);
      end
      2'b01: begin
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        ia = a;
        ib = b;
        q  = ia / ib;
        r  = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // call at a negedge where the unit can accept
  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input string nm);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    e.res  = ref_model(op, a, b);
    e.due  = cyc + 1 + LAT;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout got=%0d pending want=0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 100);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done got=1 want=0 t=%0d",
                   cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.name, {bus.hi, bus.lo}, e.res);
          chk({e.name, "_lat"}, 64'(cyc), 64'(e.due));
          chk({e.name, "_busylen"}, 64'(busy_run),
              64'(LAT));
          chk({e.name, "_busy0"}, 64'(bus.busy), 64'd0);
        end
        busy_run = 0;
        last = {bus.hi, bus.lo};
      end else if (bus.busy) begin
        chk("hold", {bus.hi, bus.lo}, last);
      end
    end
  end

  initial begin
    logic [1:0] rop;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, -32'sd3, 32'd5, "mult_m3x5");
    wait_idle();
    @(negedge clk);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    wait_idle();
    @(negedge clk);
    issue(2'b10, -32'sd7, 32'd2, "div_m7_2");
    wait_done();
    issue(2'b11, 32'd100, 32'd0, "divu_by0");
    wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    wait_done();
    issue(2'b10, -32'sd5, 32'd0, "div_m5_by0");
    wait_idle();
    @(negedge clk);

    issue(2'b00, 32'd7, 32'd9, "mult_7x9");
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.in1   = 32'd50;
    bus.in2   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    chk("mult_7x9_lo", 64'(bus.lo), 64'h3F);
    @(negedge clk);

    issue(2'b01, 32'd123, 32'd456, "aborted");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    last = '0;
    busy_run = 0;
    repeat (40) @(negedge clk);
    issue(2'b11, 32'd1000, 32'd7, "post_rst");
    wait_idle();
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      issue(rop, pick(), pick(), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
      end else begin
        wait_idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
